// File: rtl/risc_mem_responder_pkg.sv
// Shared definitions for the RISC memory responder: controller states,
// bus widths and the default memory map.
package risc_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam int ADDR_W     = 13;
    localparam int DATA_W     = 8;
    localparam int DEF_ROM_AW = 12;
    localparam int DEF_RAM_AW = 9;
    localparam logic [ADDR_W-1:0] DEF_RAM_BASE = 13'h1800;

endpackage

// File: rtl/risc_sp_ram.sv
// Synchronous single-port byte memory with a registered read port.
// The read register can be loaded with zero instead of the array word so the
// owner can return 0 for accesses that miss this memory.
module risc_sp_ram #(
    parameter int AW     = 9,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic              i_clr,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**AW)-1];
    logic [DATA_W-1:0] r_rdata;

    // Array write; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Registered read data; holds when no read is requested.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_clr ? '0 : r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/risc_mem_responder.sv
// Memory-side responder for the RISC core bus: program ROM, data RAM,
// address decode, write edge detection and a byte-stream ROM boot loader
// that keeps the core in reset until the image is in place.
module risc_mem_responder
    import risc_mem_responder_pkg::*;
#(
    parameter int                ROM_AW    = DEF_ROM_AW,
    parameter int                RAM_AW    = DEF_RAM_AW,
    parameter logic [ADDR_W-1:0] RAM_BASE  = DEF_RAM_BASE,
    parameter int                RST_HOLD  = 4,
    parameter bit                BOOT_LOAD = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rd,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rom_data,
    output logic [DATA_W-1:0] o_ram_data,
    output logic              o_cpu_reset,
    input  logic              i_ld_start,
    input  logic              i_ld_valid,
    input  logic [DATA_W-1:0] i_ld_data,
    input  logic              i_ld_last,
    output logic              o_ld_ready,
    output logic [ROM_AW:0]   o_ld_count,
    output logic              o_bus_err,
    output logic              o_ld_err
);

    localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [ROM_AW-1:0] PTR_MAX   = '1;
    localparam state_t            ST_RESET  = BOOT_LOAD ? ST_IDLE : ST_HOLD;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ROM_AW-1:0]   r_ptr;
    logic [ROM_AW:0]     r_ld_count;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_wr_prev;
    logic                r_bus_err;
    logic                r_ld_err;

    logic                w_rom_hit;
    logic                w_ram_hit;
    logic                w_run;
    logic                w_load;
    logic                w_wr_edge;
    logic                w_rd_en;
    logic                w_ram_we;
    logic                w_bus_bad;
    logic                w_ld_wr;
    logic                w_ld_ovf;
    logic [ROM_AW-1:0]   w_rom_addr;

    // Decode and access qualification; the core bus only counts in RUN.
    assign w_rom_hit  = ((i_addr >> ROM_AW) == '0);
    assign w_ram_hit  = (i_addr[ADDR_W-1:RAM_AW] == RAM_BASE[ADDR_W-1:RAM_AW]);
    assign w_run      = (r_state == ST_RUN);
    assign w_load     = (r_state == ST_LOAD);
    assign w_wr_edge  = i_wr & ~r_wr_prev;
    assign w_rd_en    = w_run & i_rd & ~i_wr;
    assign w_ram_we   = w_run & w_wr_edge & w_ram_hit;
    assign w_bus_bad  = w_run & ((w_wr_edge & ~w_ram_hit) | (i_rd & i_wr));
    // A restart request outranks a byte offered in the same cycle.
    assign w_ld_wr    = w_load & i_ld_valid & ~i_ld_start;
    assign w_ld_ovf   = w_ld_wr & ~i_ld_last & (r_ptr == PTR_MAX);
    // The loader owns the ROM port while loading, the core otherwise.
    assign w_rom_addr = w_load ? r_ptr : i_addr[ROM_AW-1:0];

    // Controller state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and Moore outputs; the core is held in reset outside RUN.
    always_comb begin
        w_state_nxt = r_state;
        o_ld_ready  = 1'b0;
        o_cpu_reset = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (i_ld_start) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                o_ld_ready = 1'b1;
                if (i_ld_start) begin
                    w_state_nxt = ST_LOAD;
                end else if (w_ld_wr && (i_ld_last || w_ld_ovf)) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_ld_start) begin
                    w_state_nxt = ST_LOAD;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                o_cpu_reset = 1'b0;
                if (i_ld_start) w_state_nxt = ST_LOAD;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Write edge tracking (runs in every state) and the HOLD cycle counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_prev  <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_wr_prev  <= i_wr;
            r_hold_cnt <= (r_state == ST_HOLD) ? r_hold_cnt + 1'b1 : '0;
        end
    end

    // Loader pointer, byte count and sticky error flags.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ptr      <= '0;
            r_ld_count <= '0;
            r_bus_err  <= 1'b0;
            r_ld_err   <= 1'b0;
        end else if (i_ld_start) begin
            r_ptr      <= '0;
            r_ld_count <= '0;
            r_bus_err  <= 1'b0;
            r_ld_err   <= 1'b0;
        end else begin
            if (w_ld_wr) begin
                r_ptr      <= r_ptr + 1'b1;
                r_ld_count <= r_ld_count + 1'b1;
            end
            if (w_ld_ovf)  r_ld_err  <= 1'b1;
            if (w_bus_bad) r_bus_err <= 1'b1;
        end
    end

    assign o_ld_count = r_ld_count;
    assign o_bus_err  = r_bus_err;
    assign o_ld_err   = r_ld_err;

    risc_sp_ram #(
        .AW     (ROM_AW),
        .DATA_W (DATA_W)
    ) u_rom (
        .i_clk   (i_clk),
        .i_rst   (i_reset),
        .i_we    (w_ld_wr),
        .i_re    (w_rd_en),
        .i_clr   (~w_rom_hit),
        .i_addr  (w_rom_addr),
        .i_wdata (i_ld_data),
        .o_rdata (o_rom_data)
    );

    risc_sp_ram #(
        .AW     (RAM_AW),
        .DATA_W (DATA_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst   (i_reset),
        .i_we    (w_ram_we),
        .i_re    (w_rd_en),
        .i_clr   (~w_ram_hit),
        .i_addr  (i_addr[RAM_AW-1:0]),
        .i_wdata (i_wr_data),
        .o_rdata (o_ram_data)
    );

endmodule

// File: tb/tb_risc_mem_responder.sv
// Bench for risc_mem_responder: directed boot/run/error scenarios mixed with
// random bytes and addresses, checked against a behavioural memory model.
module tb_risc_mem_responder;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd, wr;
    logic [12:0] addr;
    logic [7:0]  wr_data;
    logic [7:0]  rom_data, ram_data;
    logic        cpu_reset;
    logic        ld_start, ld_valid, ld_last;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic [12:0] ld_count;
    logic        bus_err, ld_err;

    int total = 0;
    int bad   = 0;

    // Behavioural model: memory images plus "has been written" flags.
    logic [7:0] rom_m [0:4095];
    bit         rom_k [0:4095];
    logic [7:0] ram_m [0:511];
    bit         ram_k [0:511];
    bit         exp_bus_err;
    bit         exp_ld_err;
    logic [7:0] fixed_q [$];

    always #5 clk = ~clk;

    risc_mem_responder #(
        .RST_HOLD  (HOLD),
        .BOOT_LOAD (1'b1)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_rd        (rd),
        .i_wr        (wr),
        .i_addr      (addr),
        .i_wr_data   (wr_data),
        .o_rom_data  (rom_data),
        .o_ram_data  (ram_data),
        .o_cpu_reset (cpu_reset),
        .i_ld_start  (ld_start),
        .i_ld_valid  (ld_valid),
        .i_ld_data   (ld_data),
        .i_ld_last   (ld_last),
        .o_ld_ready  (ld_ready),
        .o_ld_count  (ld_count),
        .o_bus_err   (bus_err),
        .o_ld_err    (ld_err)
    );

    function automatic bit is_rom(input logic [12:0] a);
        return int'(a) < 4096;
    endfunction

    function automatic bit is_ram(input logic [12:0] a);
        return (int'(a) >= 'h1800) && (int'(a) < 'h1800 + 512);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_errs(input string tag);
        chk({tag, "_bus_err"}, bus_err, exp_bus_err);
        chk({tag, "_ld_err"}, ld_err, exp_ld_err);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rom_data"}, rom_data, 0);
        chk({tag, "_ram_data"}, ram_data, 0);
        chk({tag, "_cpu_reset"}, cpu_reset, 1);
        chk({tag, "_ld_ready"}, ld_ready, 0);
        chk({tag, "_ld_count"}, ld_count, 0);
        chk({tag, "_bus_err"}, bus_err, 0);
        chk({tag, "_ld_err"}, ld_err, 0);
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        exp_bus_err = 1'b0;
        exp_ld_err  = 1'b0;
        chk("start_ld_ready", ld_ready, 1);
        chk("start_cpu_reset", cpu_reset, 1);
        chk("start_ld_count", ld_count, 0);
        chk_errs("start");
    endtask

    // Streams n bytes (queued fixed bytes first, then random) with random gaps.
    task automatic stream(input int n, input bit with_last);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                ld_valid = 1'b0;
                step();
                chk("gap_ld_ready", ld_ready, 1);
            end
            if (fixed_q.size() > 0) d = fixed_q.pop_front();
            else d = 8'($urandom);
            ld_valid = 1'b1;
            ld_data  = d;
            ld_last  = with_last && (i == n - 1);
            step();
            rom_m[i] = d;
            rom_k[i] = 1'b1;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (!with_last && n == 4096) exp_ld_err = 1'b1;
        chk("end_ld_count", ld_count, n);
        chk("end_ld_ready", ld_ready, 0);
        chk("end_cpu_reset", cpu_reset, 1);
        chk_errs("end");
        for (int k = 1; k <= HOLD; k++) begin
            step();
            chk("hold_cpu_reset", cpu_reset, (k < HOLD) ? 1 : 0);
        end
    endtask

    task automatic do_read(input logic [12:0] a);
        rd   = 1'b1;
        addr = a;
        step();
        rd   = 1'b0;
        if (is_rom(a)) begin
            if (rom_k[a[11:0]]) chk("rd_rom_data", rom_data, rom_m[a[11:0]]);
        end else begin
            chk("rd_rom_miss", rom_data, 0);
        end
        if (is_ram(a)) begin
            if (ram_k[int'(a) - 'h1800]) chk("rd_ram_data", ram_data, ram_m[int'(a) - 'h1800]);
        end else begin
            chk("rd_ram_miss", ram_data, 0);
        end
    endtask

    // wr held for len cycles; the data changes after the first edge and must not land.
    task automatic do_write(input logic [12:0] a, input logic [7:0] d, input int len);
        wr      = 1'b1;
        addr    = a;
        wr_data = d;
        step();
        for (int i = 1; i < len; i++) begin
            wr_data = ~d;
            step();
        end
        wr = 1'b0;
        step();
        if (is_ram(a)) begin
            ram_m[int'(a) - 'h1800] = d;
            ram_k[int'(a) - 'h1800] = 1'b1;
        end else begin
            exp_bus_err = 1'b1;
        end
        chk_errs("wr");
    endtask

    initial begin
        logic [12:0] a;
        logic [7:0]  d;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wr_data = '0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
        exp_bus_err = 1'b0; exp_ld_err = 1'b0;
        for (int i = 0; i < 4096; i++) rom_k[i] = 1'b0;
        for (int i = 0; i < 512; i++) ram_k[i] = 1'b0;

        // Reset values, then BOOT_LOAD keeps the core in reset while idle.
        #1;
        chk_reset_outputs("reset");
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("idle_cpu_reset", cpu_reset, 1);
        chk("idle_ld_ready", ld_ready, 0);

        // Boot load of three fixed bytes.
        fixed_q.push_back(8'hE0);
        fixed_q.push_back(8'h12);
        fixed_q.push_back(8'h34);
        start_load();
        stream(3, 1'b1);
        do_read(13'h0001);
        chk("boot_rom_byte1", rom_data, 8'h12);
        do_read(13'h0000);
        do_read(13'h0002);

        // Held write pulse commits once; RAM reads back, ROM-range read gives RAM 0.
        do_write(13'h1805, 8'hA5, 3);
        do_read(13'h1805);
        chk("ram_a5", ram_data, 8'hA5);
        do_read(13'h0005);
        do_write(13'h1810, 8'h3C, 1);

        // Read outputs hold while rd is low.
        do_read(13'h1805);
        addr = 13'h0001;
        step(); step();
        chk("hold_ram_data", ram_data, 8'hA5);
        chk("hold_rom_data", rom_data, 0);

        // Full ROM without a last marker overflows and still reaches RUN.
        start_load();
        stream(4096, 1'b0);
        chk("ovf_cpu_run", cpu_reset, 0);

        // ROM write attempt flags the bus and leaves ROM untouched.
        do_write(13'h0010, 8'h5A, 1);
        do_read(13'h0010);
        chk("rom_write_err", bus_err, 1);

        // Unmapped read returns zero without touching bus_err.
        do_read(13'h1C00);
        chk_errs("unmapped");

        // Random RAM traffic and reads over the whole map.
        for (int i = 0; i < 24; i++) begin
            a = 13'(13'h1800 + $urandom_range(0, 511));
            d = 8'($urandom);
            do_write(a, d, $urandom_range(1, 3));
        end
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: a = 13'($urandom_range(0, 4095));
                1: a = 13'(13'h1800 + $urandom_range(0, 511));
                default: a = 13'($urandom_range('h1A00, 'h1FFF));
            endcase
            do_read(a);
        end

        // Reload from RUN with wr held high across RUN re-entry: no write occurs.
        start_load();
        wr      = 1'b1;
        addr    = 13'h1810;
        wr_data = 8'h77;
        stream(5, 1'b1);
        step(); step(); step();
        wr = 1'b0;
        step();
        chk_errs("reload");
        do_read(13'h1810);
        chk("no_spurious_wr", ram_data, 8'h3C);

        // rd and wr together: write lands, read outputs hold, bus_err set.
        do_read(13'h1805);
        rd = 1'b1; wr = 1'b1; addr = 13'h1820; wr_data = 8'h99;
        step();
        rd = 1'b0; wr = 1'b0;
        ram_m['h20] = 8'h99;
        ram_k['h20] = 1'b1;
        exp_bus_err = 1'b1;
        chk("rdwr_rom_hold", rom_data, 0);
        chk("rdwr_ram_hold", ram_data, ram_m[5]);
        chk_errs("rdwr");
        step();
        do_read(13'h1820);

        // Asynchronous reset in the middle of a load.
        do_read(13'h1805);
        start_load();
        ld_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom);
            ld_data = d;
            step();
            rom_m[i] = d;
        end
        ld_valid = 1'b0;
        chk("pre_rst_count", ld_count, 2);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        step();
        rst = 1'b0;
        exp_bus_err = 1'b0;
        exp_ld_err  = 1'b0;
        step();
        chk("post_rst_cpu_reset", cpu_reset, 1);
        start_load();
        stream(3, 1'b1);
        do_read(13'h1805);
        do_read(13'h1820);
        do_read(13'h1810);
        do_read(13'h0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
